stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- N-channel, WIDTH-bit streaming multiplexer. Generalises the 2:1 data mux to N inputs with valid/ready handshakes, round-robin arbitration and a registered output stage.
- Sits between multiple producer streams and one shared consumer, for example several datapath sources feeding one bus or FIFO.
- Selection comes from internal fair arbitration, not an external sel line. The granted channel index is reported alongside the data.

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data bits per channel.
- SEL_W, $clog2(NUM_CH), width of the channel-index output. Derived; do not override.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  NUM_CH  per-channel end-of-packet flag.
- in_ready  output  NUM_CH  per-channel ready; at most one bit is high in any cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_sel  output  SEL_W  index of the channel that supplied the current beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, out_sel=0, priority pointer=0 (channel 0 highest priority), lock state cleared. in_ready is all-zero while reset is asserted.
- load_en = !out_valid | out_ready. The output register accepts a new beat only when load_en is high.
- Arbitration is combinational each cycle. The grant goes to the first channel with in_valid set, scanning from pointer upward and wrapping modulo NUM_CH.
- in_ready[i] = grant[i] & load_en. Any in_ready is combinationally dependent on in_valid and out_ready; there are no other combinational input-to-output paths.
- Transfer on channel i: in_valid[i] & in_ready[i]. On that edge:
  - out_data<=in_data[i], out_last<=in_last[i], out_sel<=i, out_valid<=1.
  - pointer<=(i+1) mod NUM_CH; i=NUM_CH-1 wraps to 0.
- load_en high with no valid input: out_valid<=0. out_data, out_last and out_sel hold their previous values.
- Stall (out_valid & !out_ready): out_data, out_last and out_sel stay stable, all in_ready=0, pointer holds.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat per cycle when out_ready stays high.
- Simultaneous pop and push (out_valid & out_ready & a granted valid input): the new beat replaces the old one in the same edge, with no bubble.
- No valid inputs: pointer holds.
- Reset mid-stall: the buffered beat is discarded and is not re-presented after reset.
- Producers must hold in_valid and in_data until accepted. The block never drops a beat that has been accepted.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - After a transfer with in_last=0, the grant locks to that channel. The remaining channels are ignored even if the locked channel drops in_valid.
  - The lock releases on the transfer with in_last=1; the pointer advances only then.
  - Reset clears the lock.
- Undefined:
  - Arbitration is re-evaluated every beat, and the pointer advances on every transfer.
  - in_last is passed through to out_last only; packets from different channels may interleave.

Decomposition:
- Package stream_mux_pkg holds:
  - the MAX_CH=16 limit constant;
  - a function that computes the next pointer modulo NUM_CH.
- Sub-module rr_arbiter (NUM_CH):
  - inputs req[NUM_CH], ptr, enable;
  - outputs one-hot grant and grant_idx;
  - purely combinational, reusable.
- Top level holds the pointer register, lock flag, output register and handshake logic.

Test Plan:
- Reset default: with NUM_CH=4, deassert rst_n, then release it with all in_valid=0 → out_valid=0, out_sel=0 and in_ready=4'b0000 in every cycle.
- Fair rotation: hold all four channels valid with data 8'hA0..8'hA3 and out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3, no bubbles.
- Backpressure: channel 2 sends 8'h55, and out_ready=0 for 3 cycles → out_data stays 8'h55 and out_sel stays 2, in_ready=0 throughout. Channel 2 then sends 8'h66 → it is accepted in the cycle out_ready returns high, and out_data=8'h66 on the next edge.
- Sparse requests with wrap: pointer=3, only channel 1 valid → channel 1 is granted and the pointer becomes 2. Next, channels 0 and 3 are both valid → channel 3 is granted first.
- Mid-stall reset: out_valid=1 holding 8'h77 and out_ready=0, pulse rst_n low asynchronously between edges → out_valid drops immediately, and 8'h77 never appears after reset.
- Packet lock (macro defined): channel 0 sends 3 beats with last on the third, while channel 1 is valid throughout → out_sel=0,0,0 then 1. With the macro undefined → out_sel=0,1,0,1.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

   // Upper bound on channel count supported by the arbiter.
   localparam int MAX_CH = 16;

   // Next round-robin pointer: one past idx, wrapping at num_ch.
   function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num_ch);
      return (idx + 32'd1 >= num_ch) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// scanning upward from ptr, wrapping modulo NUM_CH.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              enable,
   output logic [NUM_CH-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx
);

   logic             found;
   logic [SEL_W-1:0] idx;

   // Priority scan starting at ptr; the first hit wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      if (enable) begin
         for (int off = 0; off < NUM_CH; off++) begin
            idx = SEL_W'((int'(ptr) + off) % NUM_CH);
            if (!found && req[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = idx;
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration and
// a registered output stage. Reports the source channel on out_sel.
// Optional packet locking: define STREAM_MUX_PKT_LOCK_EN to hold the grant
// on one channel from its first beat until the beat carrying in_last.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_last,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_last,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);

   if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
      $error("stream_mux_rr: NUM_CH out of range 2..16");
   end

   logic [WIDTH-1:0]  ch_data [NUM_CH];
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  grant_idx;
   logic [SEL_W-1:0]  ptr;
   logic              load_en;
   logic              xfer;
   logic              ptr_adv;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // The output register can take a beat when empty or being drained.
   assign load_en = !out_valid | out_ready;

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic             locked;
   logic [SEL_W-1:0] lock_ch;

   // While a packet is open only its channel may request.
   always_comb begin
      req = in_valid;
      if (locked) begin
         req          = '0;
         req[lock_ch] = in_valid[lock_ch];
      end
   end

   // Pointer moves only when a packet closes.
   assign ptr_adv = in_last[grant_idx];

   // Open the lock on a non-last beat, close it on the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked  <= 1'b0;
         lock_ch <= '0;
      end else if (xfer) begin
         locked  <= !in_last[grant_idx];
         lock_ch <= grant_idx;
      end
   end
`else
   assign req     = in_valid;
   assign ptr_adv = 1'b1;
`endif

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req       (req),
      .ptr       (ptr),
      .enable    (load_en & rst_n),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Grants are already qualified by load_en and only go to valid requesters.
   assign in_ready = grant;
   assign xfer     = |grant;

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[grant_idx];
            out_last  <= in_last[grant_idx];
            out_sel   <= grant_idx;
            if (ptr_adv) begin
               ptr <= SEL_W'(next_ptr(32'(grant_idx), NUM_CH));
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (NUM_CH=4, WIDTH=8): directed
// scenarios with literal expectations, then randomized traffic against a
// behavioural model. Honours STREAM_MUX_PKT_LOCK_EN like the design.
module tb_stream_mux_rr;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_sel;
   logic        out_ready = 1'b0;

   bit       ch_v [N] = '{default: 1'b0};
   bit       ch_l [N] = '{default: 1'b0};
   bit [7:0] ch_d [N] = '{default: 8'h00};

   assign in_valid = {ch_v[3], ch_v[2], ch_v[1], ch_v[0]};
   assign in_last  = {ch_l[3], ch_l[2], ch_l[1], ch_l[0]};
   assign in_data  = {ch_d[3], ch_d[2], ch_d[1], ch_d[0]};

   stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the output register should hold, who has priority.
   int       m_ptr     = 0;
   bit       m_locked  = 1'b0;
   int       m_lock_ch = 0;
   bit       m_ov      = 1'b0;
   bit [7:0] m_od      = 8'h00;
   bit       m_ol      = 1'b0;
   int       m_os      = 0;
   bit       m_xfer [N] = '{default: 1'b0};

   function automatic int model_grant();
      if (m_locked) return ch_v[m_lock_ch] ? m_lock_ch : -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (ch_v[c]) return c;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int g;
      for (int c = 0; c < N; c++) m_xfer[c] = 1'b0;
      if (!rst_n) begin
         m_ptr = 0; m_locked = 1'b0; m_lock_ch = 0;
         m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_os = 0;
      end else if (!m_ov || out_ready) begin
         g = model_grant();
         if (g >= 0) begin
            m_xfer[g] = 1'b1;
            m_ov = 1'b1; m_od = ch_d[g]; m_ol = ch_l[g]; m_os = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
            m_locked  = !ch_l[g];
            m_lock_ch = g;
            if (ch_l[g]) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
         end else begin
            m_ov = 1'b0;
         end
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      int g;
      logic [3:0] er;
      g  = model_grant();
      er = (rst_n && (!m_ov || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0000;
      check("m_in_ready",  in_ready,  er);
      check("m_out_valid", out_valid, m_ov);
      check("m_out_data",  out_data,  m_od);
      check("m_out_last",  out_last,  m_ol);
      check("m_out_sel",   out_sel,   m_os);
   end

   int exp_lock_sel [4];
   int beats;

   initial begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      exp_lock_sel = '{0, 0, 0, 1};
`else
      exp_lock_sel = '{0, 1, 0, 1};
`endif
      // Reset held, then released with nothing valid.
      repeat (2) begin
         @(negedge clk);
         check("in_reset_valid", out_valid, 0);
         check("in_reset_ready", in_ready, 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_out_valid", out_valid, 0);
         check("rst_out_sel",   out_sel,   0);
         check("rst_in_ready",  in_ready,  0);
      end

      // Fair rotation with all channels busy.
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int c = 0; c < N; c++) begin
         ch_v[c] = 1'b1;
         ch_d[c] = 8'hA0 + 8'(c);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("rot_valid", out_valid, 1);
         check("rot_sel",   out_sel,   k % 4);
         check("rot_data",  out_data,  8'hA0 + 8'(k % 4));
      end
      @(posedge clk); #1;
      for (int c = 0; c < N; c++) ch_v[c] = 1'b0;
      @(posedge clk); #1;

      // Backpressure on a beat from channel 2.
      ch_v[2] = 1'b1; ch_d[2] = 8'h55;
      @(posedge clk); #1;
      out_ready = 1'b0; ch_d[2] = 8'h66;
      repeat (3) begin
         @(negedge clk);
         check("bp_data",  out_data, 8'h55);
         check("bp_sel",   out_sel,  2);
         check("bp_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_accept", in_ready, 4'b0100);
      @(posedge clk); #1;
      ch_v[2] = 1'b0; ch_v[1] = 1'b1; ch_d[1] = 8'h31;

      // Sparse requests with wrap, pointer now 3.
      @(negedge clk);
      check("bp_data2", out_data, 8'h66);
      check("bp_sel2",  out_sel,  2);
      check("sp_ready1", in_ready, 4'b0010);
      @(posedge clk); #1;
      ch_v[1] = 1'b0; ch_v[0] = 1'b1; ch_d[0] = 8'h30; ch_v[3] = 1'b1; ch_d[3] = 8'h33;
      @(negedge clk);
      check("sp_sel1",   out_sel,  1);
      check("sp_ready2", in_ready, 4'b1000);
      @(posedge clk); #1;
      ch_v[3] = 1'b0;
      @(negedge clk);
      check("sp_sel2",   out_sel,  3);
      check("sp_ready3", in_ready, 4'b0001);
      @(posedge clk); #1;
      ch_v[0] = 1'b0;

      // Reset in the middle of a stall.
      ch_v[0] = 1'b1; ch_d[0] = 8'h77;
      @(posedge clk); #1;
      ch_v[0] = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("ms_hold_valid", out_valid, 1);
      check("ms_hold_data",  out_data,  8'h77);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("ms_async_valid", out_valid, 0);
      check("ms_async_ready", in_ready,  0);
      #1 rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("ms_after_valid", out_valid, 0);
         check("ms_after_data",  out_data,  0);
      end

      // Packet on channel 0 competing with channel 1.
      @(posedge clk); #1;
      beats = 0;
      ch_v[0] = 1'b1; ch_d[0] = 8'h10; ch_l[0] = 1'b0;
      ch_v[1] = 1'b1; ch_d[1] = 8'h20; ch_l[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (m_xfer[0]) begin
            beats++;
            if (beats == 3) ch_v[0] = 1'b0;
            else begin
               ch_d[0] = 8'h10 + 8'(beats);
               ch_l[0] = (beats == 2);
            end
         end
         @(negedge clk);
         check("lock_sel", out_sel, exp_lock_sel[k]);
      end

      // Randomized traffic; producers hold each beat until it is accepted.
      repeat (3000) begin
         @(posedge clk); #1;
         for (int c = 0; c < N; c++) begin
            if (m_xfer[c] || !ch_v[c]) begin
               ch_v[c] = 1'($urandom_range(0, 1));
               ch_d[c] = 8'($urandom);
               ch_l[c] = ($urandom_range(0, 3) == 0);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
